// File: rtl/scanner_sched_if.sv
// Signal bundle between the ping-pong scheduler and its two scanners / host path.
// SCHED_XFER_COUNT_EN adds the xfer_count observation signal.
interface scanner_sched_if #(
   parameter int unsigned FILL_W = 7
);
   logic              start;
   logic              stop;
   logic [FILL_W-1:0] fill_a;
   logic [FILL_W-1:0] fill_b;
   logic              done_a;
   logic              done_b;
   logic              scan_a;
   logic              scan_b;
   logic              xfer_a;
   logic              xfer_b;
   logic              standby_a;
   logic              standby_b;
   logic              flush_a;
   logic              flush_b;
   logic              busy;
   logic              err;
   logic [2:0]        state;
`ifdef SCHED_XFER_COUNT_EN
   logic [15:0]       xfer_count;
`endif

   modport master (
      input  start, stop, fill_a, fill_b, done_a, done_b,
      output scan_a, scan_b, xfer_a, xfer_b, standby_a, standby_b,
             flush_a, flush_b, busy, err, state
`ifdef SCHED_XFER_COUNT_EN
      , output xfer_count
`endif
   );

   modport slave (
      output start, stop, fill_a, fill_b, done_a, done_b,
      input  scan_a, scan_b, xfer_a, xfer_b, standby_a, standby_b,
             flush_a, flush_b, busy, err, state
`ifdef SCHED_XFER_COUNT_EN
      , input xfer_count
`endif
   );
endinterface

// File: rtl/scanner_sched.sv
// Ping-pong scheduler for scanners A/B sharing one host transfer path, with tick-based
// transfer timeout. Define SCHED_XFER_COUNT_EN to add the done-terminated transfer counter.
module scanner_sched #(
   parameter int unsigned FILL_W       = 7,
   parameter int unsigned WAKE_LVL     = 80,
   parameter int unsigned FULL_LVL     = 100,
   parameter int unsigned TICK_DIV     = 4,
   parameter int unsigned XFER_TIMEOUT = 50
) (
   input logic            clk,
   input logic            rst,
   scanner_sched_if.master bus
);
   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRunA  = 3'd1,
      StOvlA  = 3'd2,
      StXferA = 3'd3,
      StRunB  = 3'd4,
      StOvlB  = 3'd5,
      StXferB = 3'd6
   } state_e;

   localparam int unsigned PresW = $clog2(TICK_DIV);
   localparam int unsigned TcntW = $clog2(XFER_TIMEOUT + 1);
   localparam logic [FILL_W-1:0] WakeLvl = FILL_W'(WAKE_LVL);
   localparam logic [FILL_W-1:0] FullLvl = FILL_W'(FULL_LVL);
   localparam logic [PresW-1:0]  PresMax = PresW'(TICK_DIV - 1);
   localparam logic [TcntW-1:0]  TcntMax = TcntW'(XFER_TIMEOUT);

   state_e           state_q, state_d;
   logic [PresW-1:0] pres_q, pres_d;
   logic [TcntW-1:0] tcnt_q, tcnt_d;
   logic             scan_a_q, scan_a_d, scan_b_q, scan_b_d;
   logic             standby_a_q, standby_a_d, standby_b_q, standby_b_d;
   logic             flush_a_q, flush_a_d, flush_b_q, flush_b_d;
   logic             err_q, err_d;
   logic             tick, timeout, full_a, full_b, wake_a, wake_b, in_xfer_q, in_xfer_d;

   assign tick      = (pres_q == PresMax);
   assign timeout   = (tcnt_q == TcntMax);
   assign full_a    = (bus.fill_a >= FullLvl);
   assign full_b    = (bus.fill_b >= FullLvl);
   assign wake_a    = (bus.fill_a >= WakeLvl);
   assign wake_b    = (bus.fill_b >= WakeLvl);
   assign in_xfer_q = (state_q == StXferA) || (state_q == StXferB);
   assign in_xfer_d = (state_d == StXferA) || (state_d == StXferB);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         pres_q      <= '0;
         tcnt_q      <= '0;
         scan_a_q    <= 1'b0;
         scan_b_q    <= 1'b0;
         standby_a_q <= 1'b0;
         standby_b_q <= 1'b0;
         flush_a_q   <= 1'b0;
         flush_b_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pres_q      <= pres_d;
         tcnt_q      <= tcnt_d;
         scan_a_q    <= scan_a_d;
         scan_b_q    <= scan_b_d;
         standby_a_q <= standby_a_d;
         standby_b_q <= standby_b_d;
         flush_a_q   <= flush_a_d;
         flush_b_q   <= flush_b_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (bus.start) state_d = StIdle == StIdle ? StRunA : StIdle;
         StRunA: begin
            if (bus.stop)  state_d = StIdle;
            else if (full_a) state_d = StXferA;
            else if (wake_a) state_d = StOvlA;
         end
         StOvlA:  if (full_a) state_d = StXferA;
         StXferA: if (bus.done_a || timeout) state_d = StRunB;
         StRunB: begin
            if (bus.stop)  state_d = StIdle;
            else if (full_b) state_d = StXferB;
            else if (wake_b) state_d = StOvlB;
         end
         StOvlB:  if (full_b) state_d = StXferB;
         StXferB: if (bus.done_b || timeout) state_d = StRunA;
         default: state_d = StIdle;
      endcase
   end

   // Pulses are decoded from the transition so they land in the first cycle of the new state.
   always_comb begin
      scan_a_d    = ((state_q == StIdle) && (state_d == StRunA)) ||
                    ((state_q == StRunB) && (state_d inside {StOvlB, StXferB}));
      scan_b_d    = (state_q == StRunA) && (state_d inside {StOvlA, StXferA});
      standby_a_d = ((state_q inside {StRunA, StRunB}) && (state_d == StIdle)) ||
                    ((state_q == StXferA) && bus.done_a);
      standby_b_d = ((state_q inside {StRunA, StRunB}) && (state_d == StIdle)) ||
                    ((state_q == StXferB) && bus.done_b);
      flush_a_d   = (state_q == StXferA) && !bus.done_a && timeout;
      flush_b_d   = (state_q == StXferB) && !bus.done_b && timeout;
      err_d       = err_q | flush_a_d | flush_b_d;
      pres_d      = tick ? '0 : pres_q + 1'b1;
      tcnt_d      = tcnt_q;
      if (in_xfer_d && !in_xfer_q) begin
         tcnt_d = '0;
      end else if (in_xfer_q && tick && !timeout) begin
         tcnt_d = tcnt_q + 1'b1;
      end
   end

`ifdef SCHED_XFER_COUNT_EN
   logic [15:0] xfer_count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_count_q <= '0;
      end else if (((state_q == StXferA) && bus.done_a) ||
                   ((state_q == StXferB) && bus.done_b)) begin
         xfer_count_q <= xfer_count_q + 16'd1;
      end
   end

   assign bus.xfer_count = xfer_count_q;
`endif

   assign bus.scan_a    = scan_a_q;
   assign bus.scan_b    = scan_b_q;
   assign bus.xfer_a    = (state_q == StXferA);
   assign bus.xfer_b    = (state_q == StXferB);
   assign bus.standby_a = standby_a_q;
   assign bus.standby_b = standby_b_q;
   assign bus.flush_a   = flush_a_q;
   assign bus.flush_b   = flush_b_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.err       = err_q;
   assign bus.state     = state_q;
endmodule

// File: tb/tb_scanner_sched.sv
// Bench for scanner_sched: directed vector table, multi-cycle corner sequences and a
// randomized run checked every cycle against a session-level reference model.
module tb_scanner_sched;
   localparam int unsigned FILL_W = 7;
   localparam int WAKE = 80;
   localparam int FULL = 100;
   localparam int TD   = 4;
   localparam int TO   = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;

   scanner_sched_if #(.FILL_W(FILL_W)) bus ();

   scanner_sched #(
      .FILL_W      (FILL_W),
      .WAKE_LVL    (WAKE),
      .FULL_LVL    (FULL),
      .TICK_DIV    (TD),
      .XFER_TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [12:0] got;
   assign got = {bus.state, bus.scan_a, bus.scan_b, bus.xfer_a, bus.xfer_b, bus.standby_a,
                 bus.standby_b, bus.flush_a, bus.flush_b, bus.busy, bus.err};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: which scanner owns the session, whether its partner is awake,
   // whether the host path is granted, and elapsed ticks of the current grant.
   int       m_sess;  // 0 none, 1 scanner A, 2 scanner B
   bit       m_woken, m_xfer, m_err;
   int       m_ticks, m_cyc;
   logic [15:0] m_count;
   bit       m_scan[2], m_stby[2], m_flush[2];

   task automatic model_step();
      int f[2];
      bit d[2];
      int s, o;
      bit tk;
      f[0] = int'(bus.fill_a);
      f[1] = int'(bus.fill_b);
      d[0] = bus.done_a;
      d[1] = bus.done_b;
      for (int i = 0; i < 2; i++) begin
         m_scan[i] = 0; m_stby[i] = 0; m_flush[i] = 0;
      end
      if (rst) begin
         m_sess = 0; m_woken = 0; m_xfer = 0; m_err = 0;
         m_ticks = 0; m_cyc = 0; m_count = '0;
         return;
      end
      tk = (m_cyc % TD) == TD - 1;
      m_cyc++;
      s = m_sess - 1;
      o = 1 - s;
      if (m_sess == 0) begin
         if (bus.start) begin
            m_sess = 1; m_scan[0] = 1; m_woken = 0; m_xfer = 0;
         end
      end else if (m_xfer) begin
         if (d[s]) begin
            m_stby[s] = 1; m_count = m_count + 16'd1;
            m_sess = o + 1; m_xfer = 0; m_woken = 0;
         end else if (m_ticks >= TO) begin
            m_flush[s] = 1; m_err = 1;
            m_sess = o + 1; m_xfer = 0; m_woken = 0;
         end else if (tk) begin
            m_ticks++;
         end
      end else if (!m_woken) begin
         if (bus.stop) begin
            m_stby[0] = 1; m_stby[1] = 1; m_sess = 0;
         end else if (f[s] >= FULL) begin
            m_scan[o] = 1; m_xfer = 1; m_ticks = 0;
         end else if (f[s] >= WAKE) begin
            m_scan[o] = 1; m_woken = 1;
         end
      end else if (f[s] >= FULL) begin
         m_xfer = 1; m_ticks = 0;
      end
   endtask

   function automatic logic [12:0] m_obs();
      int st;
      st = (m_sess == 0) ? 0 : (m_sess - 1) * 3 + 1 + (m_xfer ? 2 : (m_woken ? 1 : 0));
      return {3'(st), m_scan[0], m_scan[1], (m_sess == 1) && m_xfer, (m_sess == 2) && m_xfer,
              m_stby[0], m_stby[1], m_flush[0], m_flush[1], m_sess != 0, m_err};
   endfunction

   task automatic drive(input logic r, input logic st, input logic sp,
                        input logic [6:0] fa, input logic [6:0] fb,
                        input logic da, input logic db);
      rst        = r;
      bus.start  = st;
      bus.stop   = sp;
      bus.fill_a = fa;
      bus.fill_b = fb;
      bus.done_a = da;
      bus.done_b = db;
   endtask

   task automatic tick_clk();
      @(posedge clk);
      #1;
      model_step();
      check("model_obs", 32'(got), 32'(m_obs()));
`ifdef SCHED_XFER_COUNT_EN
      check("model_xfer_count", 32'(bus.xfer_count), 32'(m_count));
`endif
   endtask

   // Clock until the DUT leaves state st or the bound expires; n = cycles spent.
   task automatic wait_leave(input logic [2:0] st, input int bound, output int n);
      n = 0;
      while (bus.state == st && n < bound) begin
         tick_clk();
         n++;
      end
      check("wait_leave_bound", 32'(bus.state != st), 32'd1);
   endtask

   typedef struct {
      logic       r, st, sp;
      logic [6:0] fa, fb;
      logic       da, db;
      logic [2:0] exp_state;
      logic [9:0] exp_flags;  // scan_a scan_b xfer_a xfer_b stby_a stby_b fl_a fl_b busy err
   } vec_t;

   function automatic vec_t mk(input logic r, input logic st, input logic sp,
                               input logic [6:0] fa, input logic [6:0] fb,
                               input logic da, input logic db,
                               input logic [2:0] es, input logic [9:0] ef);
      vec_t v;
      v.r = r; v.st = st; v.sp = sp; v.fa = fa; v.fb = fb; v.da = da; v.db = db;
      v.exp_state = es; v.exp_flags = ef;
      return v;
   endfunction

   vec_t vecs[20];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   initial begin
      int n;
      int fa, fb;
      bit hit;
      vecs[0]  = mk(1, 0, 0,   0,   0, 0, 0, 3'd0, 10'b0000000000);
      vecs[1]  = mk(0, 0, 0,   0,   0, 0, 0, 3'd0, 10'b0000000000);
      vecs[2]  = mk(0, 1, 0,   0,   0, 0, 0, 3'd1, 10'b1000000010);
      vecs[3]  = mk(0, 0, 0,  79,   0, 0, 0, 3'd1, 10'b0000000010);
      vecs[4]  = mk(0, 0, 0,  80,   0, 0, 0, 3'd2, 10'b0100000010);
      vecs[5]  = mk(0, 0, 1,  90,   0, 0, 0, 3'd2, 10'b0000000010);
      vecs[6]  = mk(0, 0, 0, 100,   0, 0, 0, 3'd3, 10'b0010000010);
      vecs[7]  = mk(0, 0, 0, 100,   0, 0, 1, 3'd3, 10'b0010000010);
      vecs[8]  = mk(0, 0, 0, 100,   0, 1, 0, 3'd4, 10'b0000100010);
      vecs[9]  = mk(0, 1, 0,   0,  10, 0, 0, 3'd4, 10'b0000000010);
      vecs[10] = mk(0, 0, 1,   0,  10, 0, 0, 3'd0, 10'b0000110000);
      vecs[11] = mk(0, 1, 0,   0,   0, 0, 0, 3'd1, 10'b1000000010);
      vecs[12] = mk(0, 0, 0,  50,   0, 0, 0, 3'd1, 10'b0000000010);
      vecs[13] = mk(0, 0, 0, 100,   0, 0, 0, 3'd3, 10'b0110000010);
      vecs[14] = mk(0, 0, 0,   0,   0, 1, 0, 3'd4, 10'b0000100010);
      vecs[15] = mk(0, 0, 0,   0, 127, 0, 0, 3'd6, 10'b1001000010);
      vecs[16] = mk(0, 0, 0,   0,   0, 0, 1, 3'd1, 10'b0000010010);
      vecs[17] = mk(0, 0, 0, 120,   0, 0, 0, 3'd3, 10'b0110000010);
      vecs[18] = mk(1, 0, 0, 120,   0, 0, 0, 3'd0, 10'b0000000000);
      vecs[19] = mk(0, 0, 0,   0,   0, 0, 0, 3'd0, 10'b0000000000);

      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].r, vecs[i].st, vecs[i].sp, vecs[i].fa, vecs[i].fb, vecs[i].da, vecs[i].db);
         tick_clk();
         check($sformatf("vec%0d", i), 32'(got), 32'({vecs[i].exp_state, vecs[i].exp_flags}));
      end

      // Transfer timeout on B, then a late done_b must not clear err.
      drive(1, 0, 0, 0, 0, 0, 0);   tick_clk();
      drive(0, 1, 0, 0, 0, 0, 0);   tick_clk();
      drive(0, 0, 0, 100, 0, 0, 0); tick_clk();
      drive(0, 0, 0, 0, 0, 1, 0);   tick_clk();
      drive(0, 0, 0, 0, 100, 0, 0); tick_clk();
      check("xfer_b_entry", 32'(bus.state), 32'd6);
      drive(0, 0, 0, 0, 0, 0, 0);
      wait_leave(3'd6, 300, n);
      check("timeout_window", 32'(n >= 197 && n <= 202), 32'd1);
      check("timeout_state", 32'(bus.state), 32'd1);
      check("timeout_flush_b", 32'(bus.flush_b), 32'd1);
      check("timeout_err", 32'(bus.err), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 1);   tick_clk();
      check("err_sticky", 32'(bus.err), 32'd1);
      check("flush_b_one_cycle", 32'(bus.flush_b), 32'd0);

      // done_a arriving in the very cycle the timeout expires: done wins.
      drive(1, 0, 0, 0, 0, 0, 0);   tick_clk();
      drive(0, 1, 0, 0, 0, 0, 0);   tick_clk();
      drive(0, 0, 0, 100, 0, 0, 0); tick_clk();
      hit = 0;
      for (int i = 0; i < 300 && !hit; i++) begin
         hit = m_xfer && (m_ticks >= TO);
         drive(0, 0, 0, 0, 0, hit, 0);
         tick_clk();
      end
      check("race_seen", 32'(hit), 32'd1);
      check("race_state", 32'(bus.state), 32'd4);
      check("race_standby_a", 32'(bus.standby_a), 32'd1);
      check("race_no_flush", 32'(bus.flush_a), 32'd0);
      check("race_err_clear", 32'(bus.err), 32'd0);

`ifdef SCHED_XFER_COUNT_EN
      drive(1, 0, 0, 0, 0, 0, 0);   tick_clk();
      check("count_reset", 32'(bus.xfer_count), 32'd0);
      drive(0, 1, 0, 0, 0, 0, 0);   tick_clk();
      drive(0, 0, 0, 100, 0, 0, 0); tick_clk();
      drive(0, 0, 0, 0, 0, 1, 0);   tick_clk();
      drive(0, 0, 0, 0, 100, 0, 0); tick_clk();
      drive(0, 0, 0, 0, 0, 0, 1);   tick_clk();
      drive(0, 0, 0, 100, 0, 0, 0); tick_clk();
      drive(0, 0, 0, 0, 0, 1, 0);   tick_clk();
      check("count_three", 32'(bus.xfer_count), 32'd3);
      drive(0, 0, 0, 0, 100, 0, 0); tick_clk();
      drive(0, 0, 0, 0, 0, 0, 0);
      wait_leave(3'd6, 300, n);
      check("count_timeout_flush", 32'(bus.flush_b), 32'd1);
      check("count_after_timeout", 32'(bus.xfer_count), 32'd3);
`endif

      // Randomized run against the model.
      fa = 0;
      fb = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 49) == 0) fa = $urandom_range(0, 60);
         else if ($urandom_range(0, 2) == 0) fa = fa + $urandom_range(0, 6);
         if ($urandom_range(0, 49) == 0) fb = $urandom_range(0, 60);
         else if ($urandom_range(0, 2) == 0) fb = fb + $urandom_range(0, 6);
         if (fa > 127) fa = 127;
         if (fb > 127) fb = 127;
         drive($urandom_range(0, 999) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 39) == 0, 7'(fa), 7'(fb),
               $urandom_range(0, 99) == 0, $urandom_range(0, 99) == 0);
         tick_clk();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/scanner_sched.md
Name: scanner_sched

Overview:
Ping-pong scheduler for two scanner units (A, B) that share one host transfer path. It starts scanner A and pre-wakes scanner B when A nears full. It grants A the transfer path when A is full, then hands scanning to B and repeats symmetrically. A prescaled timebase provides transfer timeout supervision, with flush on timeout.

Parameters:
FILL_W, 7, width of scanner fill-level inputs (percent, 0-100)
WAKE_LVL, 80, fill level at which the idle partner is woken
FULL_LVL, 100, fill level that triggers transfer
TICK_DIV, 4, clk cycles per timebase tick (>=2)
XFER_TIMEOUT, 50, ticks allowed between transfer grant and done

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin scanning session (sampled in IDLE only)
stop  in  1  end session (honoured in RUN_A/RUN_B only)
fill_a  in  FILL_W  scanner A fill level
fill_b  in  FILL_W  scanner B fill level
done_a  in  1  scanner A transfer complete (1-cycle pulse)
done_b  in  1  scanner B transfer complete (1-cycle pulse)
scan_a, scan_b  out  1  1-cycle start-scan command
xfer_a, xfer_b  out  1  transfer grant, level; never both high
standby_a, standby_b  out  1  1-cycle go-to-standby command
flush_a, flush_b  out  1  1-cycle flush command
busy  out  1  high whenever state != IDLE
err  out  1  sticky timeout flag; cleared only by rst
state  out  3  debug state encoding

Behaviour:
- States and encoding: IDLE=0, RUN_A=1, OVL_A=2, XFER_A=3, RUN_B=4, OVL_B=5, XFER_B=6.
- Reset (rst high at a clk edge): state=IDLE, all command outputs 0, xfer_a/xfer_b 0, err 0, prescaler 0, timeout counter 0.
- Each state transition takes effect on the clk edge after the condition is sampled. All pulses are registered and assert in the cycle the new state is entered.
- IDLE:
  - start=1 -> pulse scan_a, go RUN_A.
- RUN_A:
  - stop=1 -> pulse standby_a and standby_b, go IDLE. stop has priority over fill checks.
  - else fill_a>=FULL_LVL -> pulse scan_b, assert xfer_a, go XFER_A. This skips OVL_A.
  - else fill_a>=WAKE_LVL -> pulse scan_b, go OVL_A.
- OVL_A:
  - fill_a>=FULL_LVL -> assert xfer_a, go XFER_A.
  - stop is ignored.
- XFER_A: xfer_a held high throughout.
  - done_a=1 -> drop xfer_a, pulse standby_a, go RUN_B.
  - Timeout counter reaches XFER_TIMEOUT ticks -> drop xfer_a, pulse flush_a, set err, go RUN_B.
  - done_a in the same cycle as timeout -> done wins; no flush, err unchanged.
- B states mirror A with roles swapped: RUN_B, OVL_B, XFER_B -> RUN_A, pulsing scan_a and standby_b/flush_b.
- Prescaler: free-running mod-TICK_DIV counter; tick is 1 cycle when counter==TICK_DIV-1.
- Timeout counter:
  - Clears on entry to any XFER state.
  - Increments on tick while in an XFER state.
  - Saturates; never wraps.
- Fill comparisons are unsigned. Values above 100 are treated as full.
- done_x outside its own XFER state is ignored.
- start outside IDLE is ignored.
- rst asserted mid-transfer: xfer drops next cycle; no standby or flush is issued.

Optional Feature:
Macro SCHED_XFER_COUNT_EN.
- Defined: adds output xfer_count (16 bits, reset 0). It increments by 1 on each done-terminated transfer (A or B), wraps 0xFFFF->0, and does not count timeouts.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- rst, then start pulse -> next cycle state=1, scan_a=1 for exactly 1 cycle, busy=1.
- RUN_A, fill_a 79->80 -> scan_b pulse, state=2. fill_a=100 -> xfer_a=1, state=3. done_a pulse -> xfer_a=0, standby_a pulse, state=4.
- RUN_A, fill_a jumps 50->100 -> scan_b and xfer_a in the same cycle, state=3.
- XFER_B, no done_b, TICK_DIV=4, XFER_TIMEOUT=50 -> after ~200 clk: flush_b pulse, err=1, state=1. err stays 1 after the subsequent done_b.
- stop in OVL_A -> ignored. After transfer, in RUN_B, stop -> standby_a and standby_b pulse, state=0, busy=0.
- rst during XFER_A -> next cycle xfer_a=0, state=0, no standby or flush pulse. With SCHED_XFER_COUNT_EN, 3 done-terminated transfers -> xfer_count=3, and a timeout does not increment it.
